// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: 2-flop synchronised rx line, centre-sampled with a bit-period down-counter.
// Latency: rx_end rises 2 + DIV_RATE/2 + 9*DIV_RATE + 1 clocks after the start edge on rx.
// Backpressure: none; each byte is offered for one cycle on rx_end and must be taken then.
`timescale 1ns/1ps
module uart_rx_unit #(
   parameter int DIV_RATE  = 260,
   parameter int DIV_WIDTH = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       rx_busy,
   output logic       rx_end,
   output logic [7:0] rx_data
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RECV = 1'b1;

   // Bit index within the frame: 0 = start, 1..8 = data LSB first, 9 = stop
   localparam logic [3:0] BIT_START = 4'd0;
   localparam logic [3:0] BIT_STOP  = 4'd9;

   // First sample lands mid start bit; later samples are one full bit apart
   localparam logic [DIV_WIDTH-1:0] DIV_HALF = DIV_WIDTH'(DIV_RATE / 2 - 1);
   localparam logic [DIV_WIDTH-1:0] DIV_FULL = DIV_WIDTH'(DIV_RATE - 1);

   logic                 sync1_q;
   logic                 sync2_q;
   logic                 rx_s;
   logic [0:0]           state_q,  state_d;
   logic [DIV_WIDTH-1:0] div_q,    div_d;
   logic [3:0]           bit_q,    bit_d;
   logic [7:0]           data_q,   data_d;
   logic                 end_q,    end_d;

   // Two-flop synchroniser; resets to the idle (high) line level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
      end
   end

   assign rx_s = sync2_q;

   // Next-state logic: start detect, bit-period countdown and per-bit sampling
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      data_d  = data_q;
      end_d   = 1'b0;
      if (state_q == ST_IDLE) begin
         if (!rx_s) begin
            state_d = ST_RECV;
            div_d   = DIV_HALF;
            bit_d   = BIT_START;
         end
      end else begin
         if (div_q != '0) begin
            div_d = div_q - DIV_WIDTH'(1);
         end else begin
            div_d = DIV_FULL;
            bit_d = bit_q + 4'd1;
            if (bit_q == BIT_START) begin
               // A high line at mid start bit was only a glitch
               if (rx_s) begin
                  state_d = ST_IDLE;
                  div_d   = '0;
                  bit_d   = '0;
               end
            end else if (bit_q == BIT_STOP) begin
               // Back to IDLE at once so a start edge right after the stop bit is caught;
               // a low stop bit is a framing error and gets no strobe
               state_d = ST_IDLE;
               div_d   = '0;
               bit_d   = '0;
               end_d   = rx_s;
            end else begin
               data_d = {rx_s, data_q[7:1]};
            end
         end
      end
   end

   // Frame state, counters, data shift register and completion strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         data_q  <= 8'h00;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         end_q   <= end_d;
      end
   end

   assign rx_busy = (state_q == ST_RECV);
   assign rx_end  = end_q;
   assign rx_data = data_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit: reset, good frames, glitch, back-to-back, framing error, mid-frame reset.
// Latency: checks exact start-edge to rx_end distance and frame-to-frame strobe spacing.
// Backpressure: not applicable; strobes are counted every cycle by a monitor.
`timescale 1ns/1ps
module tb_uart_rx_unit;

   localparam int DIV = 260;
   localparam int LAT = 2 + DIV / 2 + 9 * DIV + 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       rx_busy;
   logic       rx_end;
   logic [7:0] rx_data;

   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   int         end_cnt = 0;
   int         last_cyc = 0;
   int         prev_cyc = 0;
   logic [7:0] last_data = 8'h00;
   logic [7:0] prev_data = 8'h00;

   uart_rx_unit #(.DIV_RATE(DIV), .DIV_WIDTH(9)) dut (
      .clk     (clk),
      .reset   (reset),
      .rx      (rx),
      .rx_busy (rx_busy),
      .rx_end  (rx_end),
      .rx_data (rx_data)
   );

   // 100 MHz bench clock
   always #5 clk = ~clk;

   // Cycle counter: value k after the k-th rising edge
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor: counts every cycle rx_end is high and logs the last two strobes
   always @(negedge clk) begin
      if (rx_end === 1'b1) begin
         prev_cyc  = last_cyc;
         prev_data = last_data;
         last_cyc  = cyc;
         last_data = rx_data;
         end_cnt   = end_cnt + 1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One bit period on the line, sampling rx_busy near the bit centre
   task automatic send_bit(input logic b, output int busy_hit);
      rx = b;
      repeat (DIV / 2) @(posedge clk);
      @(negedge clk);
      busy_hit = (rx_busy === 1'b1) ? 1 : 0;
      repeat (DIV - DIV / 2) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             output int busy_hits, output int start_cyc);
      int h;
      busy_hits = 0;
      start_cyc = cyc;
      send_bit(1'b0, h);
      busy_hits += h;
      for (int i = 0; i < 8; i++) begin
         send_bit(b[i], h);
         busy_hits += h;
      end
      send_bit(stop_bit, h);
      busy_hits += h;
   endtask

   initial begin
      int n0;
      int hits;
      int sc;
      int sc2;
      int h;
      logic [7:0] f0;

      // 1. Reset state and idle line
      reset = 1'b0;
      rx    = 1'b1;
      wait_clks(5);
      check_val("rst_busy", {31'd0, rx_busy}, 32'd0);
      check_val("rst_end",  {31'd0, rx_end},  32'd0);
      check_val("rst_data", {24'd0, rx_data}, 32'h00);
      reset = 1'b1;
      wait_clks(10000);
      check_val("idle_strobes", end_cnt, 0);
      check_val("idle_busy", {31'd0, rx_busy}, 32'd0);

      // 2. Single frame 0x41
      n0 = end_cnt;
      send_frame(8'h41, 1'b1, hits, sc);
      wait_clks(5);
      check_val("f41_pulses", end_cnt - n0, 1);
      check_val("f41_data", {24'd0, last_data}, 32'h41);
      check_val("f41_latency", last_cyc - sc, LAT);
      check_val("f41_busy_hits", hits, 10);
      check_val("f41_busy_after", {31'd0, rx_busy}, 32'd0);

      // 3. 50-clock glitch on idle line
      n0 = end_cnt;
      rx = 1'b0;
      wait_clks(20);
      check_val("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
      wait_clks(30);
      rx = 1'b1;
      wait_clks(300);
      check_val("glitch_busy_lo", {31'd0, rx_busy}, 32'd0);
      check_val("glitch_no_end", end_cnt - n0, 0);
      check_val("glitch_data", {24'd0, rx_data}, 32'h41);

      // 4. Back-to-back 0x55, 0xAA with no idle gap
      n0 = end_cnt;
      send_frame(8'h55, 1'b1, hits, sc);
      send_frame(8'hAA, 1'b1, hits, sc2);
      wait_clks(5);
      check_val("b2b_pulses", end_cnt - n0, 2);
      check_val("b2b_first", {24'd0, prev_data}, 32'h55);
      check_val("b2b_second", {24'd0, last_data}, 32'hAA);
      check_val("b2b_spacing", last_cyc - prev_cyc, 10 * DIV);
      check_val("b2b_second_lat", last_cyc - sc2, LAT);

      // 5. Framing error on 0x3C, then a good 0x7E
      n0 = end_cnt;
      send_frame(8'h3C, 1'b0, hits, sc);
      rx = 1'b1;
      wait_clks(520);
      check_val("ferr_no_end", end_cnt - n0, 0);
      check_val("ferr_busy", {31'd0, rx_busy}, 32'd0);
      check_val("ferr_data_kept", {24'd0, rx_data}, 32'h3C);
      send_frame(8'h7E, 1'b1, hits, sc);
      wait_clks(5);
      check_val("f7e_pulses", end_cnt - n0, 1);
      check_val("f7e_data", {24'd0, last_data}, 32'h7E);

      // 6. Reset in the middle of bit 4 of 0xF0, then 0x12
      n0 = end_cnt;
      f0 = 8'hF0;
      send_bit(1'b0, h);
      for (int i = 0; i < 4; i++) send_bit(f0[i], h);
      rx = f0[4];
      wait_clks(DIV / 2);
      check_val("mid_busy", {31'd0, rx_busy}, 32'd1);
      check_val("mid_data", {24'd0, rx_data}, 32'h07);
      reset = 1'b0;
      #1;
      check_val("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
      check_val("mid_rst_end",  {31'd0, rx_end},  32'd0);
      check_val("mid_rst_data", {24'd0, rx_data}, 32'h00);
      rx = 1'b1;
      wait_clks(3);
      reset = 1'b1;
      wait_clks(300);
      check_val("post_rst_no_end", end_cnt - n0, 0);
      check_val("post_rst_busy", {31'd0, rx_busy}, 32'd0);
      send_frame(8'h12, 1'b1, hits, sc);
      wait_clks(5);
      check_val("f12_pulses", end_cnt - n0, 1);
      check_val("f12_data", {24'd0, rx_data}, 32'h12);
      check_val("f12_latency", last_cyc - sc, LAT);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
